// File: rtl/cut_sweep_ctrl.sv
// Exhaustive input sweep controller for a small combinational circuit-under-test.
// Applies every input vector, captures each response over a valid/ready port and folds it into a signature.
module cut_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 12,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_IN-1:0]  res_vec,
  output logic [N_OUT-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] signature
);

  typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} state_t;

  localparam logic [N_IN-1:0] LAST_VEC  = '1;
  localparam logic [7:0]      SETTLE_LD = 8'(SETTLE);

  state_t           r_state;
  logic [N_IN-1:0]  r_vec;
  logic [7:0]       r_cnt;
  logic [N_IN-1:0]  r_cut_in;
  logic             r_res_valid;
  logic [N_IN-1:0]  r_res_vec;
  logic [N_OUT-1:0] r_res_data;
  logic             r_busy;
  logic             r_done;
  logic [N_OUT-1:0] r_sig;

  logic [N_OUT-1:0] w_sig_next;
  logic [N_IN-1:0]  w_vec_inc;

  assign w_sig_next = {r_sig[N_OUT-2:0], r_sig[N_OUT-1]} ^ r_res_data;
  assign w_vec_inc  = r_vec + N_IN'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_vec       <= '0;
      r_cnt       <= '0;
      r_cut_in    <= '0;
      r_res_valid <= 1'b0;
      r_res_vec   <= '0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sig       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state  <= APPLY;
            r_vec    <= '0;
            r_cnt    <= SETTLE_LD;
            r_sig    <= '0;
            r_cut_in <= '0;
            r_busy   <= 1'b1;
          end
        end
        APPLY: begin
          if (abort) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cut_in    <= '0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state     <= EMIT;
              r_res_data  <= cut_out;
              r_res_vec   <= r_vec;
              r_res_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          // abort wins over a same-cycle handshake, so the signature stays frozen
          if (abort) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cut_in    <= '0;
          end else if (res_ready) begin
            r_res_valid <= 1'b0;
            r_sig       <= w_sig_next;
            if (r_vec == LAST_VEC) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_vec    <= w_vec_inc;
              r_cut_in <= w_vec_inc;
              r_cnt    <= SETTLE_LD;
              r_state  <= APPLY;
            end
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_cut_in <= '0;
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cut_in    <= '0;
        end
      endcase
    end
  end

  assign cut_in    = r_cut_in;
  assign res_valid = r_res_valid;
  assign res_vec   = r_res_vec;
  assign res_data  = r_res_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;

endmodule

// File: tb/tb_cut_sweep_ctrl.sv
// Directed bench for cut_sweep_ctrl: full sweeps, backpressure, stray start, abort and mid-sweep reset.
// The CUT is modelled as either an identity (zero-extended input) or a constant 12'h001.
module tb_cut_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        res_ready = 1'b1;
  logic [3:0]  cut_in;
  logic [11:0] cut_out;
  logic        res_valid;
  logic [3:0]  res_vec;
  logic [11:0] res_data;
  logic        busy;
  logic        done;
  logic [11:0] signature;

  logic        const_mode = 1'b0;
  int          errors = 0;
  int          checks = 0;

  assign cut_out = const_mode ? 12'h001 : {8'h00, cut_in};

  always #5 clk = ~clk;

  cut_sweep_ctrl #(.N_IN(4), .N_OUT(12), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cut_in(cut_in), .cut_out(cut_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_vec(res_vec), .res_data(res_data),
    .busy(busy), .done(done), .signature(signature)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_data(input int v);
    return const_mode ? 12'h001 : 12'(v);
  endfunction

  function automatic logic [11:0] rotx(input logic [11:0] s, input logic [11:0] d);
    return {s[10:0], s[11]} ^ d;
  endfunction

  // bp_vec: vector stalled for 5 cycles (-1 none); dup_vec: vector during which start is re-pulsed (-1 none)
  task automatic run_sweep(input int bp_vec, input int dup_vec, input string tag,
                           output logic [11:0] sig_out);
    int          cyc;
    int          nv;
    int          bp_cnt;
    bit          dup_done;
    bit          got_done;
    logic [11:0] sig_m;
    int          exp_cyc;
    cyc = 0; nv = 0; bp_cnt = 0; dup_done = 0; got_done = 0; sig_m = '0;
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (cyc < 200 && !got_done) begin
      if (done) begin
        got_done = 1;
      end else begin
        if (res_valid) begin
          if (nv == bp_vec && bp_cnt < 5) begin
            res_ready = 1'b0;
            bp_cnt++;
            check({tag, "_stall_vec"}, 32'(res_vec), 32'(nv));
            check({tag, "_stall_data"}, 32'(res_data), 32'(exp_data(nv)));
            check({tag, "_stall_cut_in"}, 32'(cut_in), 32'(nv));
          end else begin
            res_ready = 1'b1;
            check({tag, "_vec"}, 32'(res_vec), 32'(nv));
            check({tag, "_data"}, 32'(res_data), 32'(exp_data(nv)));
            $display("%s: vec %0d data %03h", tag, res_vec, res_data);
            sig_m = rotx(sig_m, exp_data(nv));
            nv++;
          end
          if (nv - 1 == dup_vec && !dup_done) begin
            start = 1'b1;
            dup_done = 1;
          end
        end
        tick();
        start = 1'b0;
        cyc++;
      end
    end
    exp_cyc = 32 + ((bp_vec >= 0) ? 5 : 0);
    check({tag, "_done_cycle"}, got_done ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
    check({tag, "_nvec"}, 32'(nv), 32'd16);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    check({tag, "_sig"}, 32'(signature), 32'(sig_m));
    tick();
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_cut_in_idle"}, 32'(cut_in), 32'd0);
    tick();
    tick();
    check({tag, "_sig_held"}, 32'(signature), 32'(sig_m));
    sig_out = signature;
  endtask

  initial begin
    logic [11:0] sig_a;
    logic [11:0] sig_tmp;
    logic [11:0] sig_m;
    int          nv;
    bit          found;
    bit          saw_done;

    tick();
    tick();
    check("rst_cut_in", 32'(cut_in), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_vec", 32'(res_vec), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sig", 32'(signature), 32'd0);
    rst_n = 1'b1;
    tick();

    // start together with abort in IDLE must be ignored
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle_busy", 32'(busy), 32'd0);
    tick();

    run_sweep(-1, -1, "ident", sig_a);

    const_mode = 1'b1;
    tick();
    run_sweep(-1, -1, "const", sig_tmp);
    check("const_sig_ff0", 32'(sig_tmp), 32'h0000_0FF0);
    const_mode = 1'b0;
    tick();

    run_sweep(7, -1, "bp", sig_tmp);
    check("bp_sig_same", 32'(sig_tmp), 32'(sig_a));

    run_sweep(-1, 5, "dupstart", sig_tmp);
    check("dupstart_sig_same", 32'(sig_tmp), 32'(sig_a));

    // abort at vec 3 in EMIT with ready high in the same cycle
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    sig_m = '0; nv = 0; found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (res_valid) begin
        if (nv == 3) begin
          check("abort_vec", 32'(res_vec), 32'd3);
          abort = 1'b1;
          found = 1;
        end else begin
          sig_m = rotx(sig_m, exp_data(nv));
          nv++;
        end
      end
      tick();
    end
    abort = 1'b0;
    check("abort_reached", 32'(found), 32'd1);
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sig", 32'(signature), 32'(sig_m));
    saw_done = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) saw_done = 1;
      tick();
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_sig_frozen", 32'(signature), 32'(sig_m));

    // asynchronous reset in the middle of a sweep (vec 9)
    start = 1'b1;
    tick();
    start = 1'b0;
    nv = 0; found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (res_valid) begin
        if (nv == 9) found = 1;
        else nv++;
      end
      if (!found) tick();
    end
    check("rst_mid_reached", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cut_in", 32'(cut_in), 32'd0);
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_res_vec", 32'(res_vec), 32'd0);
    check("arst_res_data", 32'(res_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sig", 32'(signature), 32'd0);
    #1;
    rst_n = 1'b1;
    saw_done = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done || busy) saw_done = 1;
    end
    check("arst_no_resume", 32'(saw_done), 32'd0);
    run_sweep(-1, -1, "post_rst", sig_tmp);
    check("post_rst_sig_same", 32'(sig_tmp), 32'(sig_a));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
